// File: rtl/count_dir_pkg.sv
// Shared encodings for the count-bus direction decoder: FSM states and step classes.
package count_dir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CLS_HOLD = 3'd0,
        CLS_UP   = 3'd1,
        CLS_DOWN = 3'd2,
        CLS_JUMP = 3'd3,
        CLS_CLR  = 3'd4
    } step_cls_e;

    function automatic logic cls_is_step(step_cls_e cls);
        return (cls == CLS_UP) || (cls == CLS_DOWN);
    endfunction

endpackage

// File: rtl/count_step_classifier.sv
// Combinational classifier: compares a new count sample with the previous one
// and names the step (hold/up/down/jump/clear), flagging wraps across all-ones<->0.
module count_step_classifier
    import count_dir_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] count_in_i,
    output step_cls_e        cls_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] delta;

    assign delta = count_in_i - prev_i;

    // Ordered tests keep the classes mutually exclusive; CLR outranks JUMP.
    always_comb begin
        if (delta == WIDTH'(1))       cls_o = CLS_UP;
        else if (delta == '1)         cls_o = CLS_DOWN;
        else if (delta == '0)         cls_o = CLS_HOLD;
        else if (count_in_i == '0)    cls_o = CLS_CLR;
        else                          cls_o = CLS_JUMP;
    end

    assign wrap_o = ((cls_o == CLS_UP)   && (prev_i == '1)) ||
                    ((cls_o == CLS_DOWN) && (prev_i == '0));

endmodule

// File: rtl/count_dir_decoder.sv
// Receive-side tracker for an up/down counter bus: recovers direction, locks after
// LOCK_N same-direction steps, reports run length and step events. Macro COUNT_DIR_HOLD_ERR_EN
// makes a hold while locked an error (counted in err_cnt, drops lock); otherwise it is ignored.
module count_dir_decoder
    import count_dir_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LOCK_N = 3,
    parameter int RUN_W  = 8,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             valid,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir_out,
    output logic             locked,
    output logic             step_evt,
    output logic             wrap_evt,
    output logic             jump_evt,
    output logic             clr_evt,
    output logic [RUN_W-1:0] run_len,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int ACQ_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [ACQ_W-1:0] acq_q, acq_d;
    logic             cand_q, cand_d;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             step_q, step_d, wrap_q, wrap_d, jump_q, jump_d, clre_q, clre_d;

    step_cls_e cls;
    logic      cls_wrap;
    logic      step_up;
    logic [RUN_W-1:0] run_inc;

    count_step_classifier #(.WIDTH(WIDTH)) u_classifier (
        .prev_i     (prev_q),
        .count_in_i (count_in),
        .cls_o      (cls),
        .wrap_o     (cls_wrap)
    );

    assign step_up = (cls == CLS_UP);
    assign run_inc = (run_q == '1) ? run_q : run_q + RUN_W'(1);

`ifdef COUNT_DIR_HOLD_ERR_EN
    logic [ERR_W-1:0] err_q, err_d;
`endif

    always_comb begin
        // NOTE: every target gets a default up front so no path can infer a latch.
        state_d = state_q;
        prev_d  = prev_q;
        acq_d   = acq_q;
        cand_d  = cand_q;
        dir_d   = dir_q;
        run_d   = run_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        jump_d  = 1'b0;
        clre_d  = 1'b0;
`ifdef COUNT_DIR_HOLD_ERR_EN
        err_d   = err_q;
`endif
        if (valid) begin
            prev_d = count_in;
            if (state_q == ST_IDLE) begin
                state_d = ST_ACQ;
                acq_d   = '0;
            end else begin
                step_d = cls_is_step(cls);
                wrap_d = cls_wrap;
                jump_d = (cls == CLS_JUMP);
                clre_d = (cls == CLS_CLR);
                if (state_q == ST_ACQ) begin
                    if (cls_is_step(cls)) begin
                        if (acq_q == '0 || step_up == cand_q) begin
                            acq_d = acq_q + ACQ_W'(1);
                            run_d = run_inc;
                        end else begin
                            acq_d = ACQ_W'(1);
                            run_d = RUN_W'(1);
                        end
                        cand_d = step_up;
                        if (acq_d >= ACQ_W'(LOCK_N)) begin
                            state_d = ST_LOCK;
                            dir_d   = step_up;
                        end
                    end else if (cls != CLS_HOLD) begin
                        acq_d = '0;
                        run_d = '0;
                    end
                end else begin
                    // Locked: a direction reversal is a legal mode change, so reacquire with it.
                    if (cls_is_step(cls)) begin
                        if (step_up == dir_q) begin
                            run_d = run_inc;
                        end else begin
                            state_d = ST_ACQ;
                            cand_d  = step_up;
                            acq_d   = ACQ_W'(1);
                            run_d   = RUN_W'(1);
                        end
                    end else if (cls != CLS_HOLD) begin
                        state_d = ST_ACQ;
                        acq_d   = '0;
                        run_d   = '0;
                    end else begin
`ifdef COUNT_DIR_HOLD_ERR_EN
                        state_d = ST_ACQ;
                        acq_d   = '0;
                        run_d   = '0;
                        err_d   = (err_q == '1) ? err_q : err_q + ERR_W'(1);
`endif
                    end
                end
            end
        end
        locked_d = (state_d == ST_LOCK);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            acq_q    <= '0;
            cand_q   <= 1'b1;
            dir_q    <= 1'b1;
            locked_q <= 1'b0;
            run_q    <= '0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            jump_q   <= 1'b0;
            clre_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            acq_q    <= acq_d;
            cand_q   <= cand_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            run_q    <= run_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            jump_q   <= jump_d;
            clre_q   <= clre_d;
        end
    end

`ifdef COUNT_DIR_HOLD_ERR_EN
    always_ff @(posedge clk) begin
        if (clr) err_q <= '0;
        else     err_q <= err_d;
    end
    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

    assign dir_out  = dir_q;
    assign locked   = locked_q;
    assign step_evt = step_q;
    assign wrap_evt = wrap_q;
    assign jump_evt = jump_q;
    assign clr_evt  = clre_q;
    assign run_len  = run_q;

endmodule
